// File: rtl/shift_arb_pkg.sv
// Shared widths, source encodings and payload types for the shift arbiter.
package shift_arb_pkg;

  localparam int unsigned MANT_W  = 24;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned GUARD_W = 1 << SHAMT_W;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef struct packed {
    logic [MANT_W-1:0]  mant;
    logic [SHAMT_W-1:0] nshift;
  } job_t;

  typedef struct packed {
    logic              valid;
    logic [MANT_W-1:0] mant;
    logic              sticky;
    logic              src;
  } res_t;

endpackage

// File: rtl/shift_arb_rshift24.sv
// Combinational 24-bit logical right shifter with sticky-bit collection.
module rshift24
  import shift_arb_pkg::*;
(
  input  logic [MANT_W-1:0]  mant,
  input  logic [SHAMT_W-1:0] nshift,
  output logic [MANT_W-1:0]  res,
  output logic               sticky
);

  localparam int unsigned EXT_W = MANT_W + GUARD_W;

  logic [EXT_W-1:0] ext;

  // Guard field is wide enough that no shifted-out bit is ever lost, so
  // sticky is simply the OR of everything below the mantissa field.
  always_comb begin
    ext    = {mant, GUARD_W'(0)} >> nshift;
    res    = ext[EXT_W-1 -: MANT_W];
    sticky = |ext[GUARD_W-1:0];
  end

endmodule

// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter sharing one right shifter, with a
// single-entry registered result stage.
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [MANT_W-1:0]  a_mant,
  input  logic [SHAMT_W-1:0] a_nshift,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [MANT_W-1:0]  b_mant,
  input  logic [SHAMT_W-1:0] b_nshift,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MANT_W-1:0]  res_mant,
  output logic               res_sticky,
  output logic               res_src
);

  logic ptr_q;
  logic ptr_d;
  res_t res_q;

  logic can_accept;
  logic grant_a;
  logic grant_b;
  job_t job;

  logic [MANT_W-1:0] sh_mant;
  logic              sh_sticky;

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= RR_INIT;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Pointer moves to the loser after a grant, holds otherwise
  always_comb begin
    ptr_d = ptr_q;
    if (grant_a) begin
      ptr_d = SRC_B;
    end else if (grant_b) begin
      ptr_d = SRC_A;
    end
  end

  // Grant decode and operand select
  always_comb begin
    can_accept = !res_q.valid || res_ready;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    job        = '0;
    if (!rst && can_accept) begin
      grant_a = a_valid && (!b_valid || (ptr_q == SRC_A));
      grant_b = b_valid && (!a_valid || (ptr_q == SRC_B));
    end
    if (grant_b) begin
      job.mant   = b_mant;
      job.nshift = b_nshift;
    end else begin
      job.mant   = a_mant;
      job.nshift = a_nshift;
    end
    a_ready = grant_a;
    b_ready = grant_b;
  end

  rshift24 u_rshift (
    .mant   (job.mant),
    .nshift (job.nshift),
    .res    (sh_mant),
    .sticky (sh_sticky)
  );

  // Result stage: load on grant, drain on consume, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (grant_a || grant_b) begin
      res_q.valid  <= 1'b1;
      res_q.mant   <= sh_mant;
      res_q.sticky <= sh_sticky;
      res_q.src    <= grant_b ? SRC_B : SRC_A;
    end else if (res_ready) begin
      res_q.valid <= 1'b0;
    end
  end

  assign res_valid  = res_q.valid;
  assign res_mant   = res_q.mant;
  assign res_sticky = res_q.sticky;
  assign res_src    = res_q.src;

endmodule

// File: tb/tb_shift_arb.sv
// Directed self-checking bench for shift_arb.
module tb_shift_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [23:0] a_mant, b_mant;
  logic [4:0]  a_nshift, b_nshift;
  logic        res_valid, res_ready;
  logic [23:0] res_mant;
  logic        res_sticky, res_src;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_arb #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_mant     (a_mant),
    .a_nshift   (a_nshift),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_mant     (b_mant),
    .b_nshift   (b_nshift),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_mant   (res_mant),
    .res_sticky (res_sticky),
    .res_src    (res_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check readies mid-cycle, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic ea, input logic eb);
    @(negedge clk);
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(ea));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic res(input string tag, input logic v, input logic [23:0] m,
                     input logic s, input logic src);
    chk({tag, ".res_valid"},  32'(res_valid),  32'(v));
    chk({tag, ".res_mant"},   32'(res_mant),   32'(m));
    chk({tag, ".res_sticky"}, 32'(res_sticky), 32'(s));
    chk({tag, ".res_src"},    32'(res_src),    32'(src));
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    a_valid = 1'b1; a_mant = 24'hFFFFFF; a_nshift = 5'd3;
    b_valid = 1'b1; b_mant = 24'hFFFFFF; b_nshift = 5'd3;

    // Reset: no grants, outputs cleared
    cyc("rst", 1'b0, 1'b0);
    res("rst", 1'b0, 24'h0, 1'b0, 1'b0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // Single A job
    a_valid = 1'b1; a_mant = 24'hF00001; a_nshift = 5'd4;
    cyc("a_only", 1'b1, 1'b0);
    res("a_only", 1'b1, 24'h0F0000, 1'b1, 1'b0);
    a_valid = 1'b0;
    cyc("drain", 1'b0, 1'b0);
    chk("drain.res_valid", 32'(res_valid), 32'd0);

    // Re-reset so the pointer starts at A, then contend for 4 cycles
    rst = 1'b1;
    cyc("rst2", 1'b0, 1'b0);
    rst = 1'b0;
    a_valid = 1'b1; a_mant = 24'h000010; a_nshift = 5'd4;
    b_valid = 1'b1; b_mant = 24'h000003; b_nshift = 5'd1;
    cyc("rr0", 1'b1, 1'b0);
    res("rr0", 1'b1, 24'h000001, 1'b0, 1'b0);
    cyc("rr1", 1'b0, 1'b1);
    res("rr1", 1'b1, 24'h000001, 1'b1, 1'b1);
    cyc("rr2", 1'b1, 1'b0);
    res("rr2", 1'b1, 24'h000001, 1'b0, 1'b0);
    cyc("rr3", 1'b0, 1'b1);
    res("rr3", 1'b1, 24'h000001, 1'b1, 1'b1);

    // Backpressure: result held, nobody granted
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 1'b0, 1'b0);
      res("hold", 1'b1, 24'h000001, 1'b1, 1'b1);
    end
    res_ready = 1'b1;
    cyc("release", 1'b1, 1'b0);
    res("release", 1'b1, 24'h000001, 1'b0, 1'b0);
    a_valid = 1'b0;

    // B boundary shifts (pointer is at B)
    b_mant = 24'h800000; b_nshift = 5'd31;
    cyc("b31", 1'b0, 1'b1);
    res("b31", 1'b1, 24'h000000, 1'b1, 1'b1);
    b_mant = 24'h000000; b_nshift = 5'd24;
    cyc("b24", 1'b0, 1'b1);
    res("b24", 1'b1, 24'h000000, 1'b0, 1'b1);
    b_valid = 1'b0;

    // A boundary shifts
    a_valid = 1'b1; a_mant = 24'h800000; a_nshift = 5'd23;
    cyc("a23", 1'b1, 1'b0);
    res("a23", 1'b1, 24'h000001, 1'b0, 1'b0);
    a_mant = 24'h800001; a_nshift = 5'd24;
    cyc("a24", 1'b1, 1'b0);
    res("a24", 1'b1, 24'h000000, 1'b1, 1'b0);
    a_mant = 24'h123456; a_nshift = 5'd0;
    cyc("a0", 1'b1, 1'b0);
    res("a0", 1'b1, 24'h123456, 1'b0, 1'b0);

    // Reset with a pending result (pointer at B beforehand)
    res_ready = 1'b0; rst = 1'b1; b_valid = 1'b1;
    cyc("rst3", 1'b0, 1'b0);
    res("rst3", 1'b0, 24'h000000, 1'b0, 1'b0);
    rst = 1'b0; res_ready = 1'b1;
    a_mant = 24'h000100; a_nshift = 5'd8;
    b_mant = 24'hFFFFFF; b_nshift = 5'd0;
    cyc("post_rst", 1'b1, 1'b0);
    res("post_rst", 1'b1, 24'h000001, 1'b0, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 Parameter: RR_INIT, default 1'b0, selects the requester that has priority after reset (0 = A, 1 = B).
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port a_valid  input  1  requester A has a shift job.
REQ-005 Port a_ready  output  1  A's job is accepted this cycle.
REQ-006 Port a_mant  input  24  A's operand mantissa.
REQ-007 Port a_nshift  input  5  A's right-shift amount, 0..31.
REQ-008 Ports b_valid, b_ready, b_mant, b_nshift SHALL mirror REQ-004..REQ-007 for requester B.
REQ-009 Port res_valid  output  1  a result is held on the res_* outputs.
REQ-010 Port res_ready  input  1  the consumer takes the result this cycle.
REQ-011 Port res_mant  output  24  the operand shifted right logically, zero-filled from the MSB.
REQ-012 Port res_sticky  output  1  OR of all operand bits shifted out.
REQ-013 Port res_src  output  1  owner of the result: 0 = A, 1 = B.

Function
REQ-014 The block SHALL share one combinational 24-bit right shifter between A and B; exactly one job SHALL be granted per cycle at most.
REQ-015 can_accept = !res_valid || res_ready; no job SHALL be granted when can_accept is low.
REQ-016 With one valid requester and can_accept high, that requester SHALL be granted.
REQ-017 With both valid, the requester named by the priority pointer SHALL be granted.
REQ-018 After any grant, the pointer SHALL move to the non-granted requester; with no grant, it SHALL hold.
REQ-019 x_ready SHALL be high only in the cycle x is granted, and SHALL NOT depend combinationally on x_valid of the other requester beyond REQ-017.
REQ-020 A job granted in cycle N SHALL appear with res_valid=1 in cycle N+1 (latency 1); throughput SHALL be one job per cycle when res_ready stays high.
REQ-021 While res_valid=1 and res_ready=0, res_mant, res_sticky and res_src SHALL hold stable.
REQ-022 When res_ready=1 and no job is granted, res_valid SHALL drop the next cycle.
REQ-023 For nshift 0, res_mant = mant and res_sticky = 0.
REQ-024 For nshift 1..23, res_mant = mant >> nshift and res_sticky = OR of mant[nshift-1:0].
REQ-025 For nshift 24..31, res_mant = 0 and res_sticky = OR of mant[23:0].
REQ-026 A requester that is held off by backpressure or by the other requester's grant SHALL be served within two grant cycles.

Reset
REQ-027 In any cycle with rst=1, a_ready and b_ready SHALL be 0.
REQ-028 After a reset cycle, res_valid, res_mant, res_sticky and res_src SHALL all be 0, and the pointer SHALL equal RR_INIT.
REQ-029 Reset asserted while a result is pending SHALL discard that result with no handshake.

Structure
REQ-030 The shared package SHALL hold MANT_W=24, SHAMT_W=5, and the source encodings SRC_A=0 and SRC_B=1.
REQ-031 The shifter SHALL be the sub-module rshift24, which is purely combinational and produces both the shifted mantissa and the sticky bit.
REQ-032 The arbitration logic, the pointer and the output register SHALL live in shift_arb.

Verification
REQ-033 Only A valid, a_mant=24'hF00001, a_nshift=4, res_ready=1 -> next cycle res_mant=24'h0F0000, res_sticky=1, res_src=0.
REQ-034 A and B valid together for 4 cycles with RR_INIT=0, res_ready=1 -> grants alternate A,B,A,B and res_src reads 0,1,0,1.
REQ-035 res_ready=0 for 3 cycles while a result is held -> res_* stay stable, both readies stay 0, and the result is taken the cycle res_ready=1.
REQ-036 b_mant=24'h800000, b_nshift=31 -> res_mant=0, res_sticky=1; b_mant=24'h000000, b_nshift=24 -> res_mant=0, res_sticky=0.
REQ-037 rst pulsed while res_valid=1 -> the next cycle has res_valid=0 and all outputs 0, and a subsequent contested grant goes to the RR_INIT requester.
REQ-038 nshift=0 with a_mant=24'h123456 -> res_mant=24'h123456 and res_sticky=0.
